// File: rtl/mix_timer.sv
// Mixer interval timer: counts MIX_TICKS or DRAIN_TICKS prescaled ticks after a Start edge, then raises TOK.
// Optional build macro MIX_TIMER_PAUSE_EN adds a Pause input that freezes a running interval.
module mix_timer #(
  parameter int PRESCALE    = 1000,
  parameter int MIX_TICKS   = 20,
  parameter int DRAIN_TICKS = 8,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sel,
`ifdef MIX_TIMER_PAUSE_EN
  input  logic             Pause,
`endif
  output logic             TOK,
  output logic             Busy,
  output logic [CNT_W-1:0] Count
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MIX_LOAD   = CNT_W'(MIX_TICKS);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             start_d_r;
  logic [PRE_W-1:0] pre_r, pre_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             tok_r, tok_s;
  logic             busy_r;
  logic             start_edge_s;
  logic             pause_s;

`ifdef MIX_TIMER_PAUSE_EN
  assign pause_s = Pause;
`else
  assign pause_s = 1'b0;
`endif

  assign start_edge_s = Start & ~start_d_r;

  // Next-state logic: a start edge overrides everything, including pause and DONE.
  always_comb begin
    state_s = state_r;
    pre_s   = pre_r;
    count_s = count_r;
    tok_s   = tok_r;
    if (start_edge_s) begin
      state_s = RUN;
      pre_s   = {PRE_W{1'b0}};
      count_s = Sel ? DRAIN_LOAD : MIX_LOAD;
      tok_s   = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (pause_s) begin
            state_s = RUN;
          end else if (count_r == {CNT_W{1'b0}}) begin
            // zero-length interval completes one cycle after the load
            state_s = DONE;
            tok_s   = 1'b1;
          end else if (pre_r == PRE_MAX) begin
            pre_s = {PRE_W{1'b0}};
            if (count_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              count_s = {CNT_W{1'b0}};
              tok_s   = 1'b1;
              state_s = DONE;
            end else begin
              count_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            pre_s = pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
          end
        end
        IDLE: state_s = IDLE;
        DONE: state_s = DONE;
        default: begin
          state_s = IDLE;
          pre_s   = {PRE_W{1'b0}};
          count_s = {CNT_W{1'b0}};
          tok_s   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      start_d_r <= 1'b0;
      pre_r     <= {PRE_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      tok_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      start_d_r <= Start;
      pre_r     <= pre_s;
      count_r   <= count_s;
      tok_r     <= tok_s;
      busy_r    <= (state_s == RUN);
    end
  end

  assign TOK   = tok_r;
  assign Busy  = busy_r;
  assign Count = count_r;

endmodule

// File: tb/tb_mix_timer.sv
// Scoreboard bench for mix_timer: directed scenarios plus random Start/Sel/Reset against a deadline-based model.
module tb_mix_timer;
  localparam int P  = 4;
  localparam int MT = 3;
  localparam int DT = 2;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Sel = 1'b0;
  logic          TOK;
  logic          Busy;
  logic [CW-1:0] Count;
`ifdef MIX_TIMER_PAUSE_EN
  logic          Pause = 1'b0;
`endif

  mix_timer #(.PRESCALE(P), .MIX_TICKS(MT), .DRAIN_TICKS(DT), .CNT_W(CW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Sel(Sel),
`ifdef MIX_TIMER_PAUSE_EN
    .Pause(Pause),
`endif
    .TOK(TOK),
    .Busy(Busy),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW+1:0] exp_q[$];

  // model: interval outcome follows from start cycle, loaded ticks and elapsed posedges
  bit m_active = 1'b0;
  bit m_prev   = 1'b0;
  int m_k      = 0;
  int m_n      = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [CW+1:0] act, input logic [CW+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got TOK/Busy/Count=%b/%b/%0d expected %b/%b/%0d",
               name, cyc, act[CW+1], act[CW], act[CW-1:0], exp[CW+1], exp[CW], exp[CW-1:0]);
    end
  endtask

  // Drive one cycle of inputs at the negedge and queue the outputs expected after the next posedge.
  task automatic cycle(input logic rst, input logic st, input logic sl);
    logic [CW+1:0] exp;
    int e;
    @(negedge Clk);
    Reset = rst;
    Start = st;
    Sel   = sl;
    if (rst) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
      exp      = '0;
      #1 chk("reset_async", {TOK, Busy, Count}, exp);
    end else begin
      if (st && !m_prev) begin
        m_active = 1'b1;
        m_k      = cyc;
        m_n      = sl ? DT : MT;
      end
      m_prev = st;
      if (!m_active) begin
        exp = '0;
      end else begin
        e = cyc - m_k;
        if ((m_n == 0 && e >= 1) || (m_n > 0 && e >= m_n * P))
          exp = {1'b1, 1'b0, CW'(0)};
        else
          exp = {1'b0, 1'b1, CW'(m_n - e / P)};
      end
    end
    exp_q.push_back(exp);
    cyc++;
  endtask

  task automatic run(input int n, input logic st, input logic sl);
    for (int i = 0; i < n; i++) cycle(1'b0, st, sl);
  endtask

  // Monitor: one queued expectation per rising edge, checked just after it.
  initial begin
    logic [CW+1:0] exp;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        chk("outputs", {TOK, Busy, Count}, exp);
      end
    end
  end

  initial begin
    logic st;
    logic rst;
    int wait_cyc;
    #1 chk("reset_initial", {TOK, Busy, Count}, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    // basic mix interval
    run(1, 1'b1, 1'b0); run(14, 1'b0, 1'b0);
    // drain interval with Sel toggled mid-run
    run(1, 1'b1, 1'b1); run(2, 1'b0, 1'b1); run(12, 1'b0, 1'b0);
    // retrigger at k+6
    run(1, 1'b1, 1'b0); run(5, 1'b0, 1'b0); run(1, 1'b1, 1'b0); run(14, 1'b0, 1'b0);
    // Start held 20 cycles, then a fresh edge out of DONE
    run(20, 1'b1, 1'b0); run(3, 1'b0, 1'b0); run(4, 1'b1, 1'b0); run(14, 1'b0, 1'b1);
    // reset pulse during RUN
    run(1, 1'b1, 1'b0); run(4, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0); run(30, 1'b0, 1'b0);
    // Start already high when reset releases
    cycle(1'b1, 1'b1, 1'b1); run(10, 1'b1, 1'b1);
    // random traffic
    st = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) st = ~st;
      rst = ($urandom_range(0, 149) == 0);
      cycle(rst, st, 1'($urandom_range(0, 1)));
    end
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge Clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
